// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a block-wide data memory.
// Hits complete combinationally in the request cycle; misses stall via BUSYWAIT while the FSM moves blocks.
module data_cache #(
    parameter int NBLOCKS  = 8,
    parameter int BLKBYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);
    localparam int IDXW = $clog2(NBLOCKS);
    localparam int OFFW = $clog2(BLKBYTES);
    localparam int TAGW = 8 - IDXW - OFFW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t state_q, state_d;
    logic   first_q;
    logic [31:0] fill_q;

    logic [NBLOCKS-1:0] valid_q;
    logic [NBLOCKS-1:0] dirty_q;
    logic [TAGW-1:0]    tag_q  [NBLOCKS];
    logic [31:0]        data_q [NBLOCKS];

    logic [TAGW-1:0] addr_tag;
    logic [IDXW-1:0] idx;
    logic [OFFW-1:0] offset;
    logic [31:0]     cur_block;
    logic [31:0]     merged_block;
    logic            hit;
    logic            write_hit;

    assign addr_tag  = ADDRESS[7 -: TAGW];
    assign idx       = ADDRESS[OFFW +: IDXW];
    assign offset    = ADDRESS[OFFW-1:0];
    assign cur_block = data_q[idx];
    assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);

    // A simultaneous READ and WRITE is a read, so the store side is suppressed.
    assign write_hit = (state_q == IDLE) && hit && WRITE && !READ;
    assign BUSYWAIT  = (READ || WRITE) && !((state_q == IDLE) && hit);
    assign READDATA  = valid_q[idx] ? cur_block[{offset, 3'b000} +: 8] : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < BLKBYTES; gi++) begin : g_lane
            assign merged_block[gi*8 +: 8] = (offset == OFFW'(gi)) ? WRITEDATA : cur_block[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (state_q == UPDATE) begin
            data_q[idx]  <= fill_q;
            tag_q[idx]   <= addr_tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (write_hit) begin
            data_q[idx]  <= merged_block;
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            // first_q marks the entry cycle of a state; memory states may not exit on it.
            first_q <= (state_d != state_q);
            if (state_q == FETCH && state_d == UPDATE)
                fill_q <= mem_readdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (state_q)
            IDLE: begin
                if ((READ || WRITE) && !hit)
                    state_d = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {tag_q[idx], idx};
                mem_writedata = cur_block;
                if (!first_q && !mem_busywait)
                    state_d = FETCH;
            end
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = ADDRESS[7:OFFW];
                if (!first_q && !mem_busywait)
                    state_d = UPDATE;
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: flat byte-array reference memory, block-level memory model with random latency,
// and a read-data scoreboard checked by an independent monitor.
module tb_data_cache;
    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_bytes [256];   // backing data memory
    logic [7:0] golden    [256];   // architectural view the CPU should observe
    logic [7:0] exp_q [$];

    logic        force_busy = 1'b0;
    logic        mem_started = 1'b0;
    logic [7:0]  mem_key;
    int          mem_cnt = 0;

    logic        seen_rd, seen_wr;
    logic [5:0]  rd_addr, wb_addr;
    logic [31:0] wb_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Block memory: each new request waits a random number of cycles, then completes.
    always @(negedge CLK) begin
        if (force_busy) begin
            mem_busywait = 1'b1;
        end else if (!(mem_read || mem_write)) begin
            mem_started  = 1'b0;
            mem_busywait = 1'b0;
        end else begin
            if (!mem_started || mem_key != {mem_read, mem_write, mem_address}) begin
                mem_started = 1'b1;
                mem_key     = {mem_read, mem_write, mem_address};
                mem_cnt     = $urandom_range(0, 3);
            end
            if (mem_cnt > 0) begin
                mem_busywait = 1'b1;
                mem_cnt--;
            end else begin
                mem_busywait = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    if (mem_write) mem_bytes[mem_address*4 + b] = mem_writedata[b*8 +: 8];
                    mem_readdata[b*8 +: 8] = mem_bytes[mem_address*4 + b];
                end
            end
        end
    end

    // Monitor: every completed load is compared against the scoreboard head.
    always @(negedge CLK) begin
        if (!RESET && READ && !BUSYWAIT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL readdata: unexpected load completion at addr 0x%0h", ADDRESS);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("readdata", {24'h0, READDATA}, {24'h0, e});
                $display("load  addr=0x%02h data=0x%02h exp=0x%02h", ADDRESS, READDATA, e);
            end
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output int cyc);
        logic done;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        if (rd) exp_q.push_back(golden[a]);
        else if (wr) golden[a] = wd;
        seen_rd = 1'b0; seen_wr = 1'b0;
        cyc = 0;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            if (mem_read) begin seen_rd = 1'b1; rd_addr = mem_address; end
            if (mem_write) begin seen_wr = 1'b1; wb_addr = mem_address; wb_data = mem_writedata; end
            if (!BUSYWAIT) done = 1'b1;
            else cyc++;
        end
        if (!done) chk("access_timeout", 32'd1, 32'd0);
        if (!rd && wr) $display("store addr=0x%02h data=0x%02h stall=%0d", a, wd, cyc);
        @(posedge CLK);
        #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        int cyc;
        READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0; RESET = 1;
        mem_busywait = 0; mem_readdata = 0;
        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);
        mem_bytes[4] = 8'h11; mem_bytes[5] = 8'h22; mem_bytes[6] = 8'h33; mem_bytes[7] = 8'h44;
        for (int i = 0; i < 256; i++) golden[i] = mem_bytes[i];

        repeat (2) @(posedge CLK);
        #1 RESET = 0;
        chk("rst_busywait", {31'h0, BUSYWAIT}, 32'd0);
        chk("rst_mem_read", {31'h0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'd0);
        chk("rst_mem_address", {26'h0, mem_address}, 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        chk("rst_readdata", {24'h0, READDATA}, 32'd0);

        access(1, 0, 8'h05, 8'h00, cyc);
        chk("t1_stalled", {31'h0, cyc > 0}, 32'd1);
        chk("t1_mem_read", {31'h0, seen_rd}, 32'd1);
        chk("t1_rd_addr", {26'h0, rd_addr}, 32'h01);
        chk("t1_no_wb", {31'h0, seen_wr}, 32'd0);

        access(1, 0, 8'h05, 8'h00, cyc);
        chk("t2_hit_stall", cyc, 32'd0);
        chk("t2_no_mem_read", {31'h0, seen_rd}, 32'd0);

        access(0, 1, 8'h07, 8'hAB, cyc);
        chk("t3_wr_stall", cyc, 32'd0);
        chk("t3_no_mem_write", {31'h0, seen_wr}, 32'd0);
        access(1, 0, 8'h07, 8'h00, cyc);
        chk("t3_rd_stall", cyc, 32'd0);

        access(1, 0, 8'h25, 8'h00, cyc);
        chk("t4_wb_seen", {31'h0, seen_wr}, 32'd1);
        chk("t4_wb_addr", {26'h0, wb_addr}, 32'h01);
        chk("t4_wb_data", wb_data, 32'hAB332211);
        chk("t4_rd_addr", {26'h0, rd_addr}, 32'h09);

        access(1, 1, 8'h25, 8'h5A, cyc);
        chk("t5_both_stall", cyc, 32'd0);
        access(1, 0, 8'h25, 8'h00, cyc);
        access(1, 0, 8'h05, 8'h00, cyc);
        chk("t5_clean_no_wb", {31'h0, seen_wr}, 32'd0);
        chk("t5_refetch", {31'h0, seen_rd}, 32'd1);

        force_busy = 1'b1;
        READ = 1; ADDRESS = 8'h45;
        repeat (3) @(negedge CLK);
        chk("t6_fetching", {31'h0, mem_read}, 32'd1);
        chk("t6_stalled", {31'h0, BUSYWAIT}, 32'd1);
        RESET = 1; READ = 0;
        @(posedge CLK);
        #1 RESET = 0;
        chk("t6_mem_read_drop", {31'h0, mem_read}, 32'd0);
        chk("t6_mem_write_low", {31'h0, mem_write}, 32'd0);
        chk("t6_busywait_low", {31'h0, BUSYWAIT}, 32'd0);
        force_busy = 1'b0;
        @(posedge CLK);
        #1;
        // Reset discards every cached line, so memory is now the architectural state.
        for (int i = 0; i < 256; i++) golden[i] = mem_bytes[i];
        access(1, 0, 8'h45, 8'h00, cyc);
        chk("t6_remiss", {31'h0, seen_rd}, 32'd1);
        chk("t6_remiss_stall", {31'h0, cyc > 0}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            int kind;
            logic [7:0] a;
            kind = $urandom_range(0, 2);
            a = 8'($urandom);
            access(kind != 1, kind != 0, a, 8'($urandom), cyc);
        end

        repeat (3) @(posedge CLK);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
